// File: rtl/writeback_stage.sv
// MIPS writeback stage: MEM/WB pipeline register, load-data formatting,
// register-file write port, halt tracking and retired-instruction counter.
module writeback_stage #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_ADDR     = 5,
    parameter logic [31:0] RETIRED_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_flush,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_mem_rdata,
    input  logic [1:0]         i_byte_offset,
    input  logic [NB_ADDR-1:0] i_wr_reg,
    input  logic               i_regWrite,
    input  logic               i_mem2Reg,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_halt,
    output logic               o_we,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_DATA-1:0] o_wr_data,
    output logic               o_halted,
    output logic [31:0]        o_retired
);

    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned NB_HALF = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_valid;
    logic                r_regwrite;
    logic [NB_ADDR-1:0]  r_wr_reg;
    logic                r_mem2reg;
    logic [1:0]          r_width;
    logic                r_sign;
    logic [1:0]          r_offset;
    logic [NB_DATA-1:0]  r_alu_result;
    logic [NB_DATA-1:0]  r_mem_rdata;
    logic                r_halt;
    logic [31:0]         r_retired;

    logic [NB_BYTE-1:0]  w_byte;
    logic [NB_HALF-1:0]  w_half;
    logic [NB_DATA-1:0]  w_load;
    logic                w_we;
    logic                w_halted;

    // MEM/WB register: frozen while halted, flush loads a bubble
    always_ff @(posedge clk) begin
        if (i_rst || (r_state == ST_RUN && i_flush)) begin
            r_valid      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_wr_reg     <= '0;
            r_mem2reg    <= 1'b0;
            r_width      <= 2'b00;
            r_sign       <= 1'b0;
            r_offset     <= 2'b00;
            r_alu_result <= '0;
            r_mem_rdata  <= '0;
            r_halt       <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_valid      <= i_valid;
            r_regwrite   <= i_regWrite;
            r_wr_reg     <= i_wr_reg;
            r_mem2reg    <= i_mem2Reg;
            r_width      <= i_width;
            r_sign       <= i_sign_flag;
            r_offset     <= i_byte_offset;
            r_alu_result <= i_alu_result;
            r_mem_rdata  <= i_mem_rdata;
            r_halt       <= i_halt;
        end
    end

    // Retired counter, saturating
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_retired <= RETIRED_RST;
        end else if (r_valid && r_state == ST_RUN && r_retired != 32'hFFFF_FFFF) begin
            r_retired <= 32'(r_retired + 32'd1);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: HALTED is left only through reset
    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_RUN && r_valid && r_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    // FSM outputs
    always_comb begin
        w_we     = 1'b0;
        w_halted = 1'b0;
        case (r_state)
            ST_RUN:    w_we     = r_valid & r_regwrite & (r_wr_reg != '0);
            ST_HALTED: w_halted = 1'b1;
            default:   w_halted = 1'b0;
        endcase
    end

    // Little-endian lane select and extension of the registered load word
    always_comb begin
        w_byte = r_mem_rdata[7:0];
        case (r_offset)
            2'd0:    w_byte = r_mem_rdata[7:0];
            2'd1:    w_byte = r_mem_rdata[15:8];
            2'd2:    w_byte = r_mem_rdata[23:16];
            default: w_byte = r_mem_rdata[31:24];
        endcase
        w_half = r_offset[1] ? r_mem_rdata[31:16] : r_mem_rdata[15:0];
        w_load = r_mem_rdata;
        case (r_width)
            2'b00:   w_load = {{(NB_DATA-NB_BYTE){r_sign & w_byte[NB_BYTE-1]}}, w_byte};
            2'b01:   w_load = {{(NB_DATA-NB_HALF){r_sign & w_half[NB_HALF-1]}}, w_half};
            default: w_load = r_mem_rdata;
        endcase
    end

    assign o_we      = w_we;
    assign o_halted  = w_halted;
    assign o_wr_addr = r_wr_reg;
    assign o_wr_data = r_mem2reg ? w_load : r_alu_result;
    assign o_retired = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage; a second instance with a
// preloaded retired counter exercises saturation.
module tb_writeback_stage;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        i_flush;
    logic [31:0] i_alu_result;
    logic [31:0] i_mem_rdata;
    logic [1:0]  i_byte_offset;
    logic [4:0]  i_wr_reg;
    logic        i_regWrite;
    logic        i_mem2Reg;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic        i_halt;

    logic        o_we;
    logic [4:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_halted;
    logic [31:0] o_retired;

    logic        s_we;
    logic [4:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_halted;
    logic [31:0] s_retired;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_retired = 32'd0;

    writeback_stage #(.NB_DATA(32), .NB_ADDR(5), .RETIRED_RST(32'h0000_0000)) dut (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_alu_result(i_alu_result), .i_mem_rdata(i_mem_rdata),
        .i_byte_offset(i_byte_offset), .i_wr_reg(i_wr_reg), .i_regWrite(i_regWrite),
        .i_mem2Reg(i_mem2Reg), .i_width(i_width), .i_sign_flag(i_sign_flag),
        .i_halt(i_halt), .o_we(o_we), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_halted(o_halted), .o_retired(o_retired)
    );

    writeback_stage #(.NB_DATA(32), .NB_ADDR(5), .RETIRED_RST(32'hFFFF_FFFD)) dut_sat (
        .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
        .i_alu_result(i_alu_result), .i_mem_rdata(i_mem_rdata),
        .i_byte_offset(i_byte_offset), .i_wr_reg(i_wr_reg), .i_regWrite(i_regWrite),
        .i_mem2Reg(i_mem2Reg), .i_width(i_width), .i_sign_flag(i_sign_flag),
        .i_halt(i_halt), .o_we(s_we), .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data),
        .o_halted(s_halted), .o_retired(s_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic rw, input logic [4:0] rd,
                             input logic m2r, input logic [1:0] w, input logic s,
                             input logic [1:0] off, input logic [31:0] alu,
                             input logic [31:0] rdata, input logic h);
        i_valid = v; i_regWrite = rw; i_wr_reg = rd; i_mem2Reg = m2r;
        i_width = w; i_sign_flag = s; i_byte_offset = off;
        i_alu_result = alu; i_mem_rdata = rdata; i_halt = h;
    endtask

    task automatic set_idle();
        set_instr(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
        i_flush = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        n_checks++;
        if (o_we !== 1'b0 || o_wr_addr !== 5'd0 || o_wr_data !== 32'd0 ||
            o_halted !== 1'b0 || o_retired !== 32'd0) begin
            n_errors++;
            $display("FAIL reset: we=%b addr=%0d data=%h halted=%b retired=%0d, want all zero",
                     o_we, o_wr_addr, o_wr_data, o_halted, o_retired);
        end
        exp_retired = 32'd0;
    endtask

    task automatic test_alu_word();
        set_instr(1'b1, 1'b1, 5'd8, 1'b0, 2'b10, 1'b0, 2'b00, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        step();
        set_idle();
        n_checks++;
        if (o_we !== 1'b1 || o_wr_addr !== 5'd8 || o_wr_data !== 32'h1234_5678) begin
            n_errors++;
            $display("FAIL alu_word: we=%b addr=%0d data=%h, want we=1 addr=8 data=12345678",
                     o_we, o_wr_addr, o_wr_data);
        end
        step();
        exp_retired = 32'd1;
        n_checks++;
        if (o_retired !== exp_retired) begin
            n_errors++;
            $display("FAIL alu_word_retired: got %0d want %0d", o_retired, exp_retired);
        end
    endtask

    // Back-to-back loads: {width, sign, offset, rdata, expected}
    task automatic test_loads();
        logic [1:0]  tw [0:17];
        logic        ts [0:17];
        logic [1:0]  to [0:17];
        logic [31:0] td [0:17];
        logic [31:0] te [0:17];
        for (int i = 0; i < 8; i++) begin
            tw[i] = 2'b00; ts[i] = (i < 4); to[i] = 2'(i % 4); td[i] = 32'h80FF_7F01;
        end
        te[0] = 32'h0000_0001; te[1] = 32'h0000_007F; te[2] = 32'hFFFF_FFFF; te[3] = 32'hFFFF_FF80;
        te[4] = 32'h0000_0001; te[5] = 32'h0000_007F; te[6] = 32'h0000_00FF; te[7] = 32'h0000_0080;
        for (int i = 8; i < 16; i++) begin
            tw[i] = 2'b01; ts[i] = (i < 12); to[i] = 2'(i % 4); td[i] = 32'h8001_F00F;
        end
        te[8]  = 32'hFFFF_F00F; te[9]  = 32'hFFFF_F00F; te[10] = 32'hFFFF_8001; te[11] = 32'hFFFF_8001;
        te[12] = 32'h0000_F00F; te[13] = 32'h0000_F00F; te[14] = 32'h0000_8001; te[15] = 32'h0000_8001;
        tw[16] = 2'b10; ts[16] = 1'b1; to[16] = 2'd3; td[16] = 32'h8001_F00F; te[16] = 32'h8001_F00F;
        tw[17] = 2'b11; ts[17] = 1'b1; to[17] = 2'd1; td[17] = 32'h80FF_7F01; te[17] = 32'h80FF_7F01;
        for (int i = 0; i < 18; i++) begin
            set_instr(1'b1, 1'b1, 5'd5, 1'b1, tw[i], ts[i], to[i], 32'h5555_5555, td[i], 1'b0);
            step();
            n_checks++;
            if (o_we !== 1'b1 || o_wr_data !== te[i]) begin
                n_errors++;
                $display("FAIL load_%0d (w=%b s=%b off=%0d): we=%b data=%h want we=1 data=%h",
                         i, tw[i], ts[i], to[i], o_we, o_wr_data, te[i]);
            end
        end
        set_idle();
        step();
        exp_retired = exp_retired + 32'd18;
        n_checks++;
        if (o_retired !== exp_retired) begin
            n_errors++;
            $display("FAIL loads_retired: got %0d want %0d", o_retired, exp_retired);
        end
    endtask

    task automatic test_reg0_flush();
        set_instr(1'b1, 1'b1, 5'd0, 1'b0, 2'b10, 1'b0, 2'b00, 32'hDEAD_0000, 32'd0, 1'b0);
        step();
        set_idle();
        n_checks++;
        if (o_we !== 1'b0) begin
            n_errors++;
            $display("FAIL reg0_we: got %b want 0", o_we);
        end
        step();
        exp_retired = exp_retired + 32'd1;
        n_checks++;
        if (o_retired !== exp_retired) begin
            n_errors++;
            $display("FAIL reg0_retired: got %0d want %0d", o_retired, exp_retired);
        end
        set_instr(1'b1, 1'b1, 5'd9, 1'b0, 2'b10, 1'b0, 2'b00, 32'hCAFE_0009, 32'd0, 1'b0);
        i_flush = 1'b1;
        step();
        set_idle();
        n_checks++;
        if (o_we !== 1'b0 || o_wr_addr !== 5'd0) begin
            n_errors++;
            $display("FAIL flush_we: we=%b addr=%0d want we=0 addr=0", o_we, o_wr_addr);
        end
        step();
        n_checks++;
        if (o_retired !== exp_retired) begin
            n_errors++;
            $display("FAIL flush_retired: got %0d want %0d", o_retired, exp_retired);
        end
    endtask

    // 3 writes, HALT (regWrite=1), 2 writes, then idle: 4 writes, 4 retired
    task automatic test_halt();
        int writes = 0;
        logic [4:0]  rd   [0:5];
        logic        hflag[0:5];
        logic        exp_h[0:5];
        rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3; rd[3] = 5'd4; rd[4] = 5'd5; rd[5] = 5'd6;
        for (int i = 0; i < 6; i++) begin
            hflag[i] = (i == 3);
            exp_h[i] = (i >= 4);
        end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_instr(1'b1, 1'b1, rd[i], 1'b0, 2'b10, 1'b0, 2'b00, 32'(i + 100), 32'd0, hflag[i]);
            step();
            if (o_we === 1'b1) writes++;
            n_checks++;
            if (o_halted !== exp_h[i]) begin
                n_errors++;
                $display("FAIL halt_flag_%0d: got %b want %b", i, o_halted, exp_h[i]);
            end
        end
        set_idle();
        for (int i = 0; i < 3; i++) begin
            step();
            if (o_we === 1'b1) writes++;
        end
        n_checks++;
        if (writes != 4) begin
            n_errors++;
            $display("FAIL halt_writes: got %0d want 4", writes);
        end
        n_checks++;
        if (o_retired !== 32'd4 || o_halted !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_frozen: retired=%0d halted=%b want 4 and 1", o_retired, o_halted);
        end
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        n_checks++;
        if (o_we !== 1'b0 || o_wr_addr !== 5'd0 || o_wr_data !== 32'd0 ||
            o_halted !== 1'b0 || o_retired !== 32'd0) begin
            n_errors++;
            $display("FAIL halt_reset: we=%b addr=%0d data=%h halted=%b retired=%0d want zeros",
                     o_we, o_wr_addr, o_wr_data, o_halted, o_retired);
        end
        set_instr(1'b1, 1'b1, 5'd7, 1'b0, 2'b10, 1'b0, 2'b00, 32'h0000_0777, 32'd0, 1'b0);
        step();
        set_idle();
        n_checks++;
        if (o_we !== 1'b1 || o_wr_addr !== 5'd7 || o_wr_data !== 32'h0000_0777) begin
            n_errors++;
            $display("FAIL after_reset_write: we=%b addr=%0d data=%h want 1/7/00000777",
                     o_we, o_wr_addr, o_wr_data);
        end
        step();
    endtask

    task automatic test_saturation();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        n_checks++;
        if (s_retired !== 32'hFFFF_FFFD) begin
            n_errors++;
            $display("FAIL sat_preload: got %h want FFFFFFFD", s_retired);
        end
        set_instr(1'b1, 1'b0, 5'd3, 1'b0, 2'b10, 1'b0, 2'b00, 32'd1, 32'd0, 1'b0);
        step();
        step();
        n_checks++;
        if (s_retired !== 32'hFFFF_FFFE) begin
            n_errors++;
            $display("FAIL sat_step1: got %h want FFFFFFFE", s_retired);
        end
        step();
        set_idle();
        step();
        step();
        n_checks++;
        if (s_retired !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL sat_hold: got %h want FFFFFFFF", s_retired);
        end
    endtask

    initial begin
        i_rst = 1'b0;
        set_idle();
        step();
        test_reset();
        test_alu_word();
        test_loads();
        test_reg0_flush();
        test_halt();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
